// File: rtl/rv_imem_loader.sv
// rv_imem_loader
// ----------------------------------------------------------------------------
// Word-organised instruction memory with a byte-stream loader front end.
// Bytes arriving on the s_* stream are packed little-endian into a 32-bit
// buffer and committed to memory one word per COMMIT cycle. The core fetch
// port is registered (1-cycle latency) and is blocked while a load runs.
//
// Memory contents are X until loaded.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_start        1-cycle pulse, starts a load at byte address 0 (IDLE only)
//   load_len          byte count, sampled with load_start, clamped to memory size
//   s_valid/s_data    byte stream in
//   s_ready           byte stream ready (high only in LOAD)
//   load_busy         high while the loader FSM is out of IDLE
//   load_done         1-cycle pulse after the last word is committed
//   fetch_req/addr    core fetch request, byte address
//   fetch_valid/data  registered fetch response
//   fetch_misaligned  pulses with fetch_valid when fetch_addr[1:0] != 0
//   fetch_stall       equals load_busy
//   dbg_state         loader FSM state (IDLE=0, LOAD=1, COMMIT=2, DONE=3)
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready are
// both high; s_ready does not depend on s_valid.
// ----------------------------------------------------------------------------
module rv_imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10,
  parameter     INIT_FILE   = "INSTRUCTION_memfile.mem"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              load_busy,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_misaligned,
  output logic              fetch_stall,
  output logic [1:0]        dbg_state
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]         buf_q, buf_d;
  logic [WORD_AW-1:0]  word_ptr_q, word_ptr_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [31:0]         fetch_data_q, fetch_data_d;
  logic                fetch_mis_q, fetch_mis_d;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                hs;
  logic [ADDR_W:0]     byte_cnt_inc;
  logic                fetch_acc;
  logic [31:0]         rd_word;

  assign hs           = s_valid && s_ready;
  assign byte_cnt_inc = byte_cnt_q + 1'b1;

  // --------------------------------------------------------------------------
  // State register (FSM + datapath flops)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      buf_q         <= '0;
      word_ptr_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_mis_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      buf_q         <= buf_d;
      word_ptr_q    <= word_ptr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_mis_q   <= fetch_mis_d;
    end
  end

  // Memory array: deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state_q == ST_COMMIT) begin
      mem[word_ptr_q] <= buf_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = (load_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Commit when the top lane fills or the final byte arrives.
        if (hs && ((byte_cnt_q[1:0] == 2'd3) || (byte_cnt_inc == len_q))) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = (byte_cnt_q == len_q) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    word_ptr_d = word_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          len_d      = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          byte_cnt_d = '0;
          buf_d      = '0;
          word_ptr_d = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          buf_d[{byte_cnt_q[1:0], 3'b000} +: 8] = s_data;
          byte_cnt_d = byte_cnt_inc;
        end
      end
      ST_COMMIT: begin
        // Clearing here makes unfilled lanes of a final partial word zero.
        // After the last word of a full-size load the pointer rolls to 0,
        // but no further commit happens before a new load re-clears it.
        buf_d      = '0;
        word_ptr_d = word_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch path next values
  // --------------------------------------------------------------------------
  assign fetch_acc = fetch_req && (state_q == ST_IDLE);
  assign rd_word   = mem[fetch_addr[ADDR_W-1:2]];

  always_comb begin
    fetch_valid_d = fetch_acc;
    fetch_mis_d   = fetch_acc && (fetch_addr[1:0] != 2'b00);
    fetch_data_d  = fetch_data_q;
    if (fetch_acc) begin
      fetch_data_d = (fetch_addr[1:0] != 2'b00) ? 32'h0 : rd_word;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready          = (state_q == ST_LOAD);
    load_busy        = (state_q != ST_IDLE);
    load_done        = (state_q == ST_DONE);
    fetch_stall      = (state_q != ST_IDLE);
    fetch_valid      = fetch_valid_q;
    fetch_data       = fetch_data_q;
    fetch_misaligned = fetch_mis_q;
    dbg_state        = state_q;
  end

endmodule

// File: tb/tb_rv_imem_loader.sv
module tb_rv_imem_loader;

  localparam int ADDR_W = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready;
  logic              load_busy;
  logic              load_done;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              fetch_misaligned;
  logic              fetch_stall;
  logic [1:0]        dbg_state;

  rv_imem_loader #(.DEPTH_WORDS(256), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_misaligned(fetch_misaligned), .fetch_stall(fetch_stall),
    .dbg_state(dbg_state)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] ld_bytes [1024];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = (ADDR_W+1)'(len);
    tick();
    load_start = 1'b0;
  endtask

  // Streams ld_bytes until load_done (bounded). busy_pulse_at >= 0 raises a
  // load_start at that cycle while the load is in progress.
  task automatic feed(input int len, input bit gaps, input int busy_pulse_at,
                      output int cycles, output int fed, output int low_cnt,
                      output int done_cnt);
    bit hs;
    cycles = 0; fed = 0; low_cnt = 0; done_cnt = 0;
    while (done_cnt == 0 && cycles < 3000) begin
      if (load_done) begin
        done_cnt = 1;
      end else begin
        if (fed < len && fed < 1024 && (!gaps || $urandom_range(0, 2) != 0)) begin
          s_valid = 1'b1; s_data = ld_bytes[fed];
        end else begin
          s_valid = 1'b0; s_data = 8'h00;
        end
        load_start = (cycles == busy_pulse_at);
        load_len   = 11'd4;
        if (!s_ready && load_busy) low_cnt++;
        hs = s_valid && s_ready;
        tick();
        cycles++;
        if (hs) fed++;
        load_start = 1'b0;
      end
    end
    s_valid = 1'b0;
    tick();
    if (load_done) done_cnt++;
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] addr, output logic v,
                          output logic [31:0] d, output logic m);
    fetch_req = 1'b1; fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    v = fetch_valid; d = fetch_data; m = fetch_misaligned;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else pass_cnt++;
    chk_cnt++; if (load_busy !== 1'b0) $display("FAIL rst_load_busy got %b want 0", load_busy); else pass_cnt++;
    chk_cnt++; if (load_done !== 1'b0) $display("FAIL rst_load_done got %b want 0", load_done); else pass_cnt++;
    chk_cnt++; if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); else pass_cnt++;
    chk_cnt++; if (fetch_data !== 32'h0) $display("FAIL rst_fetch_data got %h want 0", fetch_data); else pass_cnt++;
    chk_cnt++; if (fetch_misaligned !== 1'b0) $display("FAIL rst_misaligned got %b want 0", fetch_misaligned); else pass_cnt++;
    chk_cnt++; if (fetch_stall !== 1'b0) $display("FAIL rst_stall got %b want 0", fetch_stall); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic check_word(input string name, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] exp);
    logic v, m; logic [31:0] d;
    do_fetch(addr, v, d, m);
    chk_cnt++;
    if (v !== 1'b1 || d !== exp || m !== 1'b0)
      $display("FAIL %s addr %h got v=%b d=%h m=%b want v=1 d=%h m=0", name, addr, v, d, m, exp);
    else pass_cnt++;
  endtask

  task automatic test_gap_load();
    int cyc, fed, low, dn;
    logic [31:0] exp_q[$];
    for (int i = 0; i < 16; i++) ld_bytes[i] = 8'(8'h10 + i);
    start_load(16);
    feed(16, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 20) $display("FAIL gapless_cycles got %0d want 20", cyc); else pass_cnt++;
    chk_cnt++; if (low !== 4) $display("FAIL gapless_ready_low got %0d want 4", low); else pass_cnt++;
    exp_q = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    for (int w = 0; w < 4; w++) check_word("gapless_word", ADDR_W'(w * 4), exp_q[w]);
    for (int i = 0; i < 16; i++) ld_bytes[i] = 8'(8'h40 + i);
    start_load(16);
    feed(16, 1'b1, -1, cyc, fed, low, dn);
    chk_cnt++; if (fed !== 16 || dn !== 1) $display("FAIL gap_done got fed=%0d done=%0d want 16/1", fed, dn); else pass_cnt++;
    chk_cnt++; if (low !== 4) $display("FAIL gap_ready_low got %0d want 4", low); else pass_cnt++;
    exp_q = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
    for (int w = 0; w < 4; w++) check_word("gap_word", ADDR_W'(w * 4), exp_q[w]);
  endtask

  task automatic test_partial();
    int cyc, fed, low, dn;
    ld_bytes[0] = 8'hAA; ld_bytes[1] = 8'hBB; ld_bytes[2] = 8'hCC;
    ld_bytes[3] = 8'hDD; ld_bytes[4] = 8'hEE;
    start_load(5);
    feed(5, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 7 || dn !== 1) $display("FAIL partial_cycles got %0d/%0d want 7/1", cyc, dn); else pass_cnt++;
    check_word("partial_w0", 10'h000, 32'hDDCCBBAA);
    check_word("partial_w1", 10'h004, 32'h000000EE);
    check_word("partial_w2_kept", 10'h008, 32'h4B4A4948);
  endtask

  task automatic test_full8();
    int cyc, fed, low, dn;
    ld_bytes[0] = 8'h13; ld_bytes[1] = 8'h00; ld_bytes[2] = 8'h00; ld_bytes[3] = 8'h00;
    ld_bytes[4] = 8'h93; ld_bytes[5] = 8'h00; ld_bytes[6] = 8'h10; ld_bytes[7] = 8'h00;
    start_load(8);
    feed(8, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 10) $display("FAIL full8_cycles got %0d want 10", cyc); else pass_cnt++;
    chk_cnt++; if (dn !== 1) $display("FAIL full8_done_pulses got %0d want 1", dn); else pass_cnt++;
    chk_cnt++; if (low !== 2) $display("FAIL full8_ready_low got %0d want 2", low); else pass_cnt++;
    check_word("full8_w0", 10'h000, 32'h00000013);
    check_word("full8_w1", 10'h004, 32'h00100093);
  endtask

  task automatic test_fetch();
    logic v, m; logic [31:0] d;
    int cyc, fed, low, dn;
    do_fetch(10'h004, v, d, m);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h00100093) $display("FAIL fetch4 got v=%b d=%h want 1/00100093", v, d); else pass_cnt++;
    tick();
    chk_cnt++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h00100093) $display("FAIL fetch_hold got v=%b d=%h want 0/00100093", fetch_valid, fetch_data); else pass_cnt++;
    do_fetch(10'h006, v, d, m);
    chk_cnt++; if (v !== 1'b1 || m !== 1'b1 || d !== 32'h0) $display("FAIL fetch_misaligned got v=%b m=%b d=%h want 1/1/0", v, m, d); else pass_cnt++;
    tick();
    chk_cnt++; if (fetch_misaligned !== 1'b0) $display("FAIL misaligned_pulse got %b want 0", fetch_misaligned); else pass_cnt++;
    check_word("fetch_c", 10'h00C, 32'h4F4E4D4C);
    // Simultaneous load_start and fetch_req in IDLE
    load_start = 1'b1; load_len = 11'd4; fetch_req = 1'b1; fetch_addr = 10'h004;
    tick();
    load_start = 1'b0;
    chk_cnt++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h00100093 || load_busy !== 1'b1)
      $display("FAIL simul_start got v=%b d=%h busy=%b want 1/00100093/1", fetch_valid, fetch_data, load_busy); else pass_cnt++;
    tick();
    chk_cnt++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1)
      $display("FAIL fetch_during_load got v=%b stall=%b want 0/1", fetch_valid, fetch_stall); else pass_cnt++;
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) ld_bytes[i] = 8'(i + 1);
    feed(4, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 5 || dn !== 1) $display("FAIL simul_load got %0d/%0d want 5/1", cyc, dn); else pass_cnt++;
    check_word("simul_w0", 10'h000, 32'h04030201);
  endtask

  task automatic test_len_zero();
    int cyc, fed, low, dn;
    start_load(0);
    feed(0, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 0 || dn !== 1) $display("FAIL len0 got cyc=%0d done=%0d want 0/1", cyc, dn); else pass_cnt++;
    check_word("len0_w0", 10'h000, 32'h04030201);
    check_word("len0_w1", 10'h004, 32'h00100093);
  endtask

  task automatic test_busy_start();
    int cyc, fed, low, dn;
    for (int i = 0; i < 8; i++) ld_bytes[i] = 8'(8'hA0 + i);
    start_load(8);
    feed(8, 1'b0, 2, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 10 || fed !== 8 || dn !== 1) $display("FAIL busy_start got cyc=%0d fed=%0d done=%0d want 10/8/1", cyc, fed, dn); else pass_cnt++;
    check_word("busy_w0", 10'h000, 32'hA3A2A1A0);
    check_word("busy_w1", 10'h004, 32'hA7A6A5A4);
  endtask

  task automatic test_reset_mid();
    int cyc, fed, low, dn;
    for (int i = 0; i < 8; i++) ld_bytes[i] = 8'(8'hC0 + i);
    start_load(8);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = ld_bytes[i];
      tick();
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (s_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 || fetch_stall !== 1'b0)
      $display("FAIL midrst_ctrl got rdy=%b busy=%b done=%b stall=%b want 0000", s_ready, load_busy, load_done, fetch_stall); else pass_cnt++;
    chk_cnt++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0 || fetch_misaligned !== 1'b0)
      $display("FAIL midrst_fetch got v=%b d=%h m=%b want 0/0/0", fetch_valid, fetch_data, fetch_misaligned); else pass_cnt++;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_cnt++; if (load_done !== 1'b0) $display("FAIL midrst_no_done got %b want 0", load_done); else pass_cnt++;
    check_word("midrst_w0_kept", 10'h000, 32'hA3A2A1A0);
    for (int i = 0; i < 4; i++) ld_bytes[i] = 8'(8'hD0 + i);
    start_load(4);
    feed(4, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 5 || dn !== 1) $display("FAIL midrst_reload got %0d/%0d want 5/1", cyc, dn); else pass_cnt++;
    check_word("midrst_new_w0", 10'h000, 32'hD3D2D1D0);
    check_word("midrst_w1_kept", 10'h004, 32'hA7A6A5A4);
  endtask

  task automatic test_clamp();
    int cyc, fed, low, dn;
    for (int i = 0; i < 1024; i++) ld_bytes[i] = 8'(i) ^ 8'h5A;
    start_load(1100);
    feed(1100, 1'b0, -1, cyc, fed, low, dn);
    chk_cnt++; if (cyc !== 1280 || fed !== 1024 || dn !== 1)
      $display("FAIL clamp got cyc=%0d fed=%0d done=%0d want 1280/1024/1", cyc, fed, dn); else pass_cnt++;
    check_word("clamp_first", 10'h000, 32'h59585B5A);
    check_word("clamp_last", 10'h3FC, 32'hA5A4A7A6);
  endtask

  // Sequence + final report
  initial begin
    test_reset();
    test_gap_load();
    test_partial();
    test_full8();
    test_fetch();
    test_len_zero();
    test_busy_start();
    test_reset_mid();
    test_clamp();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
